// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO-to-stream burst reader.
package fifo_stream_pkg;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } reader_state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry in-order buffer between the FIFO read data and the output stream.
module stream_skid_buffer
    import fifo_stream_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATAWIDTH-1:0]  push_data,
    input  logic                  pop,
    output logic [DATAWIDTH-1:0]  head_data,
    output logic [SKID_CNT_W-1:0] count
);

    logic [DATAWIDTH-1:0]  mem [SKID_DEPTH];
    logic [SKID_CNT_W-1:0] count_q;
    logic                  wr_sel;

    // Slot for an incoming word once this cycle's pop has shifted the queue.
    assign wr_sel    = pop ? (count_q == SKID_CNT_W'(2)) : (count_q != '0);
    assign head_data = mem[0];
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            count_q <= '0;
        end else begin
            if (pop) begin
                mem[0] <= mem[1];
            end
            if (push) begin
                mem[wr_sel] <= push_data;
            end
            count_q <= count_q + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a burst of len words from a registered-output FIFO onto a valid/ready stream.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 fifo_empty,
    output logic                 fifo_read_en,
    input  logic [DATAWIDTH-1:0] fifo_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    reader_state_t         state_q, state_d;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      issued_q;
    logic [LEN_W-1:0]      delivered_q;
    logic                  inflight_q;
    logic                  done_phase_q;
    logic [SKID_CNT_W-1:0] skid_count;
    logic [SKID_CNT_W:0]   occupancy;
    logic                  pop;

    stream_skid_buffer #(
        .DATAWIDTH (DATAWIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_data),
        .pop       (pop),
        .head_data (out_data),
        .count     (skid_count)
    );

    assign out_valid = (skid_count != '0);
    assign pop       = out_valid & out_ready;
    assign out_last  = out_valid & (delivered_q == len_q - LEN_W'(1));
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) & done_phase_q;

    // A word leaving this cycle frees its slot, so back-to-back reads keep 1 word/cycle.
    assign occupancy = {1'b0, skid_count} + (SKID_CNT_W + 1)'(inflight_q)
                     - (SKID_CNT_W + 1)'(pop);

    assign fifo_read_en = ~rst & (state_q == RUN) & ~fifo_empty & (issued_q < len_q)
                        & (occupancy < (SKID_CNT_W + 1)'(SKID_DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? DONE : RUN;
            RUN:     if (issued_q == len_q) state_d = FLUSH;
            FLUSH:   if (pop & out_last) state_d = DONE;
            DONE:    if (done_phase_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            issued_q     <= '0;
            delivered_q  <= '0;
            inflight_q   <= 1'b0;
            done_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= fifo_read_en;
            // DONE dwells two cycles; the pulse marks the second.
            done_phase_q <= (state_q == DONE) & ~done_phase_q;
            if ((state_q == IDLE) && start) begin
                len_q       <= len;
                issued_q    <= '0;
                delivered_q <= '0;
            end else begin
                if (fifo_read_en) issued_q <= issued_q + LEN_W'(1);
                if (pop) delivered_q <= delivered_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: FIFO model upstream, scoreboard monitor on the output stream.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic        fifo_empty;
    logic        fifo_read_en;
    logic [31:0] fifo_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] fmem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [32:0] exp_q [$];
    logic [63:0] re_m, ov_m, dn_m, bz_m;

    fifo_stream_reader #(
        .DATAWIDTH (32),
        .LEN_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .fifo_empty   (fifo_empty),
        .fifo_read_en (fifo_read_en),
        .fifo_data    (fifo_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Registered-output FIFO: data appears the cycle after an accepted read.
    always @(posedge clk) begin
        if (fifo_read_en) begin
            if (fifo_empty) begin
                miscompares++;
                $display("FAIL read_while_empty: fifo_read_en=1 with fifo_empty=1 at %0t", $time);
            end else begin
                fifo_data <= fmem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got data=%h last=%b, required no transfer",
                         out_data, out_last);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    miscompares++;
                    $display("FAIL sb_word: got data=%h last=%b, required data=%h last=%b",
                             out_data, out_last, e[31:0], e[32]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic fifo_put(input logic [31:0] v);
        fmem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic expect_word(input logic [31:0] v, input logic last);
        exp_q.push_back({last, v});
    endtask

    task automatic clear_masks();
        re_m = '0; ov_m = '0; dn_m = '0; bz_m = '0;
    endtask

    // Sample cycle c at the falling edge, then move to just after the next rising edge.
    task automatic step(input int c);
        @(negedge clk);
        re_m[c] = fifo_read_en;
        ov_m[c] = out_valid;
        dn_m[c] = done;
        bz_m[c] = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input int c, input logic [15:0] l);
        start = (c == 0);
        if (c == 0) len = l;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] held;
        logic        stable;

        rst = 1'b1; start = 1'b0; len = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {fifo_read_en, out_valid, out_last, busy, done, out_data},
            '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Burst of 4 at full rate
        for (int i = 0; i < 4; i++) fifo_put(32'h10 + i);
        for (int i = 0; i < 4; i++) expect_word(32'h10 + i, i == 3);
        out_ready = 1'b1;
        clear_masks();
        for (int c = 0; c < 12; c++) begin
            drive_start(c, 16'd4);
            step(c);
        end
        chk("t1_read_en", re_m, 64'h1E);
        chk("t1_valid", ov_m, 64'h78);
        chk("t1_done", dn_m, 64'h100);
        chk("t1_busy", bz_m, 64'h1FE);
        idle(2);

        // Zero-length burst
        clear_masks();
        for (int c = 0; c < 6; c++) begin
            drive_start(c, 16'd0);
            step(c);
        end
        chk("t2_read_en", re_m, 64'h0);
        chk("t2_valid", ov_m, 64'h0);
        chk("t2_done", dn_m, 64'h4);
        chk("t2_busy", bz_m, 64'h6);
        idle(2);

        // Backpressure: out_ready low for cycles 0..10
        for (int i = 0; i < 8; i++) fifo_put(32'h20 + i);
        for (int i = 0; i < 8; i++) expect_word(32'h20 + i, i == 7);
        out_ready = 1'b0;
        clear_masks();
        held = '0;
        stable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            drive_start(c, 16'd8);
            out_ready = (c >= 11);
            if (c == 3) held = out_data;
            if (c > 3 && c <= 10 && out_data !== held) stable = 1'b0;
            step(c);
        end
        chk("t3_reads_held", 64'($countones(re_m & 64'h7FF)), 64'd2);
        chk("t3_held_word", {32'h0, held}, 64'h20);
        chk("t3_stable", {63'h0, stable}, 64'h1);
        chk("t3_done_once", 64'($countones(dn_m)), 64'd1);
        idle(2);

        // FIFO runs dry after 3 of 6 words, refilled at cycle 8
        for (int i = 0; i < 3; i++) fifo_put(32'h30 + i);
        for (int i = 0; i < 6; i++) expect_word(32'h30 + i, i == 5);
        out_ready = 1'b1;
        clear_masks();
        for (int c = 0; c < 18; c++) begin
            drive_start(c, 16'd6);
            if (c == 8) for (int i = 3; i < 6; i++) fifo_put(32'h30 + i);
            step(c);
        end
        chk("t4_read_en", re_m, 64'h70E);
        chk("t4_valid", ov_m, 64'h1C38);
        chk("t4_done", dn_m, 64'h4000);
        chk("t4_busy", bz_m, 64'h7FFE);
        idle(2);

        // Reset with one word in flight and one buffered
        for (int i = 0; i < 4; i++) fifo_put(32'h40 + i);
        out_ready = 1'b0;
        clear_masks();
        for (int c = 0; c < 4; c++) begin
            drive_start(c, 16'd4);
            rst = (c == 3);
            step(c);
        end
        rst = 1'b0;
        chk("t5_pre_reset_valid", ov_m & 64'hF, 64'h8);
        chk("t5_after_reset", {fifo_read_en, out_valid, out_last, busy, done, out_data},
            '0);
        expect_word(32'h42, 1'b0);
        expect_word(32'h43, 1'b1);
        out_ready = 1'b1;
        clear_masks();
        for (int c = 0; c < 10; c++) begin
            drive_start(c, 16'd2);
            step(c);
        end
        chk("t5_read_en", re_m, 64'h6);
        chk("t5_done", dn_m, 64'h40);
        chk("t5_fifo_drained", 64'(rd_ptr), 64'(wr_ptr));
        idle(2);

        // start re-pulsed mid-burst is ignored
        for (int i = 0; i < 4; i++) fifo_put(32'h50 + i);
        for (int i = 0; i < 4; i++) expect_word(32'h50 + i, i == 3);
        clear_masks();
        for (int c = 0; c < 12; c++) begin
            drive_start(c, 16'd4);
            if (c == 2) begin
                start = 1'b1;
                len = 16'd7;
            end
            step(c);
        end
        chk("t6_read_en", re_m, 64'h1E);
        chk("t6_done", dn_m, 64'h100);
        idle(3);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
